// File: rtl/ksa_pipe_stream.sv
// Streaming Kogge-Stone add/sub, registered every REG_EVERY prefix levels, valid/ready on both sides.
// Optional: define KSA_PIPE_SAT_EN to clamp signed-overflowing results (out_sat flags the clamp).
module ksa_pipe_stream #(
  parameter int BITS      = 64,
  parameter int LEVELS    = 6,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  in_a,
  input  logic [BITS-1:0]  in_b,
  input  logic             in_c,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_sat,
  output logic [TAG_W-1:0] out_tag
);
  localparam int NG = (LEVELS + REG_EVERY - 1) / REG_EVERY;
  localparam int NS = 1 + NG;

  // pb is the bit-level propagate kept for the final xor; g/p are group prefixes
  typedef struct packed {
    logic [BITS-1:0]  pb;
    logic [BITS-1:0]  g;
    logic [BITS-1:0]  p;
    logic             cin;
    logic             amsb;
    logic             bmsb;
    logic [TAG_W-1:0] tag;
  } pg_t;

  typedef struct packed {
    logic [BITS-1:0]  sum;
    logic             cout;
    logic             ovf;
    logic             sat;
    logic [TAG_W-1:0] tag;
  } res_t;

  function automatic logic [2*BITS-1:0] lvl(input logic [BITS-1:0] g, input logic [BITS-1:0] p,
                                             input int d);
    logic [BITS-1:0] keep;
    keep = ~({BITS{1'b1}} << d);
    return {g | (p & (g << d)), p & ((p << d) | keep)};
  endfunction

  function automatic pg_t prefix(input pg_t x, input int grp);
    pg_t y;
    y = x;
    for (int l = 0; l < LEVELS; l++)
      if (l / REG_EVERY == grp) {y.g, y.p} = lvl(y.g, y.p, 1 << l);
    return y;
  endfunction

  function automatic res_t finish(input pg_t x);
    logic [BITS-1:0] g, p, sum;
    res_t r;
    g = x.g;
    p = x.p;
    for (int l = 0; l < LEVELS; l++)
      if (l / REG_EVERY == NG - 1) {g, p} = lvl(g, p, 1 << l);
    sum    = x.pb ^ {g[BITS-2:0], x.cin};
    r.cout = g[BITS-1];
    r.ovf  = (x.amsb == x.bmsb) && (sum[BITS-1] != x.amsb);
    r.sat  = 1'b0;
    r.tag  = x.tag;
`ifdef KSA_PIPE_SAT_EN
    if (r.ovf) begin
      sum   = {x.amsb, {(BITS-1){~x.amsb}}};
      r.sat = 1'b1;
    end
`endif
    r.sum = sum;
    return r;
  endfunction

  logic [NS-1:0]   vld_pipe, vld_nxt, adv, ld;
  logic            room;
  logic [BITS-1:0] beff;
  logic            cin_eff;
  pg_t             stg_q [NS-1];
  pg_t             stg_d [NS-1];
  res_t            res_q, res_d;

  assign beff    = in_sub ? ~in_b : in_b;
  assign cin_eff = in_sub ^ in_c;

  // carry-in is folded into bit 0's generate so the prefix tree yields carries directly
  always_comb begin
    stg_d[0].pb   = in_a ^ beff;
    stg_d[0].p    = in_a ^ beff;
    stg_d[0].g    = (in_a & beff) | {{(BITS-1){1'b0}}, (in_a[0] ^ beff[0]) & cin_eff};
    stg_d[0].cin  = cin_eff;
    stg_d[0].amsb = in_a[BITS-1];
    stg_d[0].bmsb = beff[BITS-1];
    stg_d[0].tag  = in_tag;
    for (int s = 1; s < NS - 1; s++) stg_d[s] = prefix(stg_q[s-1], s - 1);
    res_d = finish(stg_q[NS-2]);
  end

  // room walks back from the output: a stage may load when downstream is empty or leaving
  always_comb begin
    room = out_ready;
    adv  = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      adv[k] = vld_pipe[k] & room;
      room   = ~vld_pipe[k] | adv[k];
    end
    in_ready = room;
    ld       = {adv[NS-2:0], in_valid & room};
    vld_nxt  = ld | (vld_pipe & ~adv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      res_q    <= '0;
      for (int s = 0; s < NS - 1; s++) stg_q[s] <= '0;
    end else begin
      vld_pipe <= vld_nxt;
      for (int s = 0; s < NS - 1; s++)
        if (ld[s]) stg_q[s] <= stg_d[s];
      if (ld[NS-1]) res_q <= res_d;
    end
  end

  assign out_valid = vld_pipe[NS-1];
  assign out_sum   = res_q.sum;
  assign out_cout  = res_q.cout;
  assign out_ovf   = res_q.ovf;
  assign out_sat   = res_q.sat;
  assign out_tag   = res_q.tag;
endmodule
